// File: rtl/logic_op_arbiter.sv
// Shares one AND/OR/XOR unit among N_REQ requesters via a round-robin grant and a valid/ack result register.
// Define LOGIC_OP_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module logic_op_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 8,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [2*N_REQ-1:0]       op,
  input  logic [WIDTH*N_REQ-1:0]   a,
  input  logic [WIDTH*N_REQ-1:0]   b,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  input  logic                     rsp_ack
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cap_op_q, cap_op_d;
  logic [WIDTH-1:0]  cap_a_q, cap_a_d;
  logic [WIDTH-1:0]  cap_b_q, cap_b_d;
  logic [ID_W-1:0]   cap_id_q, cap_id_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              busy_q, busy_d;
`ifndef LOGIC_OP_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]   ptr_q, ptr_d;
`endif

  logic              found;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W-1:0]   scan_idx;
  int unsigned       scan_sum;
  logic [1:0]        sel_op;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic [WIDTH-1:0]  exec_result;

  // Winner search: first set req bit starting at ptr (or at 0 in fixed-priority builds).
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    scan_sum = 0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef LOGIC_OP_ARB_FIXED_PRIO_EN
      scan_sum = k;
`else
      scan_sum = int'(ptr_q) + k;
      if (scan_sum >= N_REQ) scan_sum = scan_sum - N_REQ;
`endif
      scan_idx = ID_W'(scan_sum);
      if (!found && req[scan_idx]) begin
        found   = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == ID_W'(i)) begin
        sel_op = op[2*i +: 2];
        sel_a  = a[WIDTH*i +: WIDTH];
        sel_b  = b[WIDTH*i +: WIDTH];
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (state_q == IDLE && !rst && found) gnt[win_idx] = 1'b1;
  end

  always_comb begin
    case (cap_op_q)
      2'd0:    exec_result = cap_a_q & cap_b_q;
      2'd1:    exec_result = cap_a_q | cap_b_q;
      2'd2:    exec_result = cap_a_q ^ cap_b_q;
      default: exec_result = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cap_op_d   = cap_op_q;
    cap_a_d    = cap_a_q;
    cap_b_d    = cap_b_q;
    cap_id_d   = cap_id_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
`ifndef LOGIC_OP_ARB_FIXED_PRIO_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          cap_op_d = sel_op;
          cap_a_d  = sel_a;
          cap_b_d  = sel_b;
          cap_id_d = win_idx;
          state_d  = EXEC;
`ifndef LOGIC_OP_ARB_FIXED_PRIO_EN
          ptr_d    = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);
`endif
        end
      end
      EXEC: begin
        rsp_data_d = exec_result;
        rsp_id_d   = cap_id_q;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d      = (state_d != IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cap_op_q    <= '0;
      cap_a_q     <= '0;
      cap_b_q     <= '0;
      cap_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifndef LOGIC_OP_ARB_FIXED_PRIO_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cap_op_q    <= cap_op_d;
      cap_a_q     <= cap_a_d;
      cap_b_q     <= cap_b_d;
      cap_id_q    <= cap_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
`ifndef LOGIC_OP_ARB_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed bench for logic_op_arbiter with an expected-result queue popped on each response.
module tb_logic_op_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;

  logic                   clk;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [2*N_REQ-1:0]     op;
  logic [WIDTH*N_REQ-1:0] a;
  logic [WIDTH*N_REQ-1:0] b;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic                   rsp_valid;
  logic [1:0]             rsp_id;
  logic [WIDTH-1:0]       rsp_data;
  logic                   rsp_ack;

  typedef struct {
    int         id;
    logic [7:0] data;
  } expT;

  expT sb[$];
  int  checks = 0;
  int  errors = 0;
  int  rrOrder[5];

  logic_op_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .a(a), .b(b),
    .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ack(rsp_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] modelOp(input logic [1:0] opc, input logic [7:0] av, input logic [7:0] bv);
    case (opc)
      2'd0:    return av & bv;
      2'd1:    return av | bv;
      2'd2:    return av ^ bv;
      default: return 8'h00;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Lanes other than the intended winner get random junk so ignored inputs really are ignored.
  task automatic applyStimulus(input logic [3:0] mask, input int id, input logic [1:0] opc,
                               input logic [7:0] av, input logic [7:0] bv);
    for (int i = 0; i < N_REQ; i++) begin
      op[2*i +: 2]         = 2'($urandom);
      a[WIDTH*i +: WIDTH]  = 8'($urandom);
      b[WIDTH*i +: WIDTH]  = 8'($urandom);
    end
    op[2*id +: 2]        = opc;
    a[WIDTH*id +: WIDTH] = av;
    b[WIDTH*id +: WIDTH] = bv;
    req = mask;
  endtask

  task automatic popCompare(input string tag);
    expT e;
    checkOutput({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({tag, "_data"}, 32'(rsp_data), 32'(e.data));
      checkOutput({tag, "_id"}, 32'(rsp_id), 32'(e.id));
    end
  endtask

  task automatic resetPulse();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge in IDLE; leaves the bench at a negedge back in IDLE.
  task automatic runTxn(input string tag, input logic [3:0] mask, input int id, input logic [1:0] opc,
                        input logic [7:0] av, input logic [7:0] bv, input logic [7:0] expData);
    expT e;
    applyStimulus(mask, id, opc, av, bv);
    #1;
    checkOutput({tag, "_gnt"}, 32'(gnt), 32'(1) << id);
    e.id = id;
    e.data = expData;
    sb.push_back(e);
    @(negedge clk);
    req = '0;
    #1;
    checkOutput({tag, "_exec_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #1;
    checkOutput({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    popCompare(tag);
    rsp_ack = 1'b1;
    @(negedge clk);
    rsp_ack = 1'b0;
    #1;
    checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_idle_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    expT e;
`ifdef LOGIC_OP_ARB_FIXED_PRIO_EN
    rrOrder = '{0, 0, 0, 0, 0};
`else
    rrOrder = '{0, 1, 2, 3, 0};
`endif
    rst = 1'b1;
    req = '0;
    op = '0;
    a = '0;
    b = '0;
    rsp_ack = 1'b0;

    // Reset state, with requests present while rst is high.
    @(negedge clk);
    req = 4'b1111;
    @(negedge clk);
    #1;
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_id", 32'(rsp_id), 32'd0);
    checkOutput("rst_data", 32'(rsp_data), 32'd0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;

    // Single XOR op, then hold the response with ack low.
    applyStimulus(4'b0001, 0, 2'd2, 8'hF0, 8'h3C);
    #1;
    checkOutput("single_gnt", 32'(gnt), 32'b0001);
    e.id = 0;
    e.data = 8'hCC;
    sb.push_back(e);
    @(negedge clk);
    req = '0;
    #1;
    checkOutput("single_exec_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("single_valid", 32'(rsp_valid), 32'd1);
    popCompare("single");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_data", 32'(rsp_data), 32'hCC);
      checkOutput("hold_id", 32'(rsp_id), 32'd0);
      checkOutput("hold_busy", 32'(busy), 32'd1);
    end
    rsp_ack = 1'b1;
    @(negedge clk);
    rsp_ack = 1'b0;
    #1;
    checkOutput("single_release", 32'(rsp_valid), 32'd0);

    // All opcodes from requester 2.
    runTxn("op_and", 4'b0100, 2, 2'd0, 8'hAA, 8'h0F, 8'h0A);
    runTxn("op_or",  4'b0100, 2, 2'd1, 8'hAA, 8'h0F, 8'hAF);
    runTxn("op_xor", 4'b0100, 2, 2'd2, 8'hAA, 8'h0F, 8'hA5);
    runTxn("op_zero", 4'b0100, 2, 2'd3, 8'hAA, 8'h0F, 8'h00);

    // Round-robin with all requesters asserting and ack held high.
    resetPulse();
    for (int i = 0; i < N_REQ; i++) begin
      op[2*i +: 2]        = 2'(i);
      a[WIDTH*i +: WIDTH] = 8'(8'h13 * (i + 1));
      b[WIDTH*i +: WIDTH] = 8'h5A;
    end
    req = 4'b1111;
    rsp_ack = 1'b1;
    for (int g = 0; g < 5; g++) begin
      #1;
      checkOutput("rr_gnt", 32'(gnt), 32'(1) << rrOrder[g]);
      e.id = rrOrder[g];
      e.data = modelOp(2'(rrOrder[g]), 8'(8'h13 * (rrOrder[g] + 1)), 8'h5A);
      sb.push_back(e);
      @(negedge clk);
      #1;
      checkOutput("rr_exec_gnt", 32'(gnt), 32'd0);
      checkOutput("rr_exec_busy", 32'(busy), 32'd1);
      @(negedge clk);
      #1;
      checkOutput("rr_valid", 32'(rsp_valid), 32'd1);
      popCompare("rr");
      @(negedge clk);
    end
    req = '0;
    rsp_ack = 1'b0;
    #1;
    checkOutput("rr_end_busy", 32'(busy), 32'd0);

    // Pointer skip: after granting 1, req=0011 scans from 2 and wraps to 0.
    runTxn("skip_first", 4'b0010, 1, 2'd1, 8'h81, 8'h42, 8'hC3);
    runTxn("skip_wrap", 4'b0011, 0, 2'd0, 8'hF3, 8'h3F, 8'h33);

    // Reset during EXEC discards the transaction.
    applyStimulus(4'b0001, 0, 2'd1, 8'h12, 8'h34);
    #1;
    checkOutput("midrst_gnt", 32'(gnt), 32'b0001);
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midrst_data", 32'(rsp_data), 32'd0);
    checkOutput("midrst_id", 32'(rsp_id), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checkOutput("midrst_no_valid", 32'(rsp_valid), 32'd0);
    end
    @(negedge clk);
    runTxn("post_rst", 4'b1000, 3, 2'd2, 8'h5C, 8'hC5, 8'h99);

    // Stray ack while idle with no requests.
    resetPulse();
    rsp_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      checkOutput("stray_gnt", 32'(gnt), 32'd0);
      checkOutput("stray_busy", 32'(busy), 32'd0);
      checkOutput("stray_valid", 32'(rsp_valid), 32'd0);
      checkOutput("stray_data", 32'(rsp_data), 32'd0);
      checkOutput("stray_id", 32'(rsp_id), 32'd0);
    end
    rsp_ack = 1'b0;
    @(negedge clk);
    runTxn("after_stray", 4'b0100, 2, 2'd0, 8'h3C, 8'hF0, 8'h30);

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
